// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master memory bus arbiter/sequencer; MEM_ARB_ROUND_ROBIN_EN enables round-robin tie-break
module mem_bus_arbiter #(
  parameter int ADDR_LENGTH  = 32,
  parameter int DATA_LENGTH  = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m0_req,
  input  logic                   m0_we,
  input  logic [ADDR_LENGTH-1:0] m0_addr,
  input  logic [DATA_LENGTH-1:0] m0_wdata,
  output logic                   m0_gnt,
  output logic                   m0_rvalid,
  output logic [DATA_LENGTH-1:0] m0_rdata,
  input  logic                   m1_req,
  input  logic                   m1_we,
  input  logic [ADDR_LENGTH-1:0] m1_addr,
  input  logic [DATA_LENGTH-1:0] m1_wdata,
  output logic                   m1_gnt,
  output logic                   m1_rvalid,
  output logic [DATA_LENGTH-1:0] m1_rdata,
  output logic                   mem_re,
  output logic                   mem_we,
  output logic [ADDR_LENGTH-1:0] mem_addr,
  output logic [DATA_LENGTH-1:0] mem_wdata,
  input  logic [DATA_LENGTH-1:0] mem_rdata,
  output logic                   busy,
  output logic                   owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_t                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [ADDR_LENGTH-1:0] addr_q, addr_d;
  logic [DATA_LENGTH-1:0] wdata_q, wdata_d;
  logic [DATA_LENGTH-1:0] rdata_q, rdata_d;
  logic                   we_q, we_d;
  logic                   owner_q, owner_d;
  logic                   last_q, last_d;
  logic [1:0]             gnt_q, gnt_d;
  logic [1:0]             rvalid_q, rvalid_d;
  logic                   mem_re_q, mem_re_d;
  logic                   mem_we_q, mem_we_d;
  logic                   win;
  logic                   win_we;

  // Strobes and grants are computed one cycle early so that every output comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    we_d     = we_q;
    owner_d  = owner_q;
    last_d   = last_q;
    gnt_d    = 2'b00;
    rvalid_d = 2'b00;
    mem_re_d = 1'b0;
    mem_we_d = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    win = (m0_req && m1_req) ? ~last_q : ~m0_req;
`else
    win = ~m0_req;
`endif
    win_we = win ? m1_we : m0_we;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          addr_d     = win ? m1_addr : m0_addr;
          wdata_d    = win ? m1_wdata : m0_wdata;
          we_d       = win_we;
          owner_d    = win;
          last_d     = win;
          mem_re_d   = ~win_we;
          mem_we_d   = win_we;
          gnt_d[win] = 1'b1;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = LAT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rdata_d           = mem_rdata;
          rvalid_d[owner_q] = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      gnt_q    <= 2'b00;
      rvalid_q <= 2'b00;
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      we_q     <= we_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      mem_re_q <= mem_re_d;
      mem_we_q <= mem_we_d;
    end
  end

  assign m0_gnt    = gnt_q[0];
  assign m1_gnt    = gnt_q[1];
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = rdata_q;
  assign m1_rdata  = rdata_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - bench for mem_bus_arbiter at READ_LATENCY 1 and 3; honours MEM_ARB_ROUND_ROBIN_EN
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req     [2][2];
  logic        wei     [2][2];
  logic [31:0] addr_i  [2][2];
  logic [31:0] wdata_i [2][2];
  logic        gnt     [2][2];
  logic        rvalid  [2][2];
  logic [31:0] rdata_o [2][2];
  logic        mem_re    [2];
  logic        mem_we    [2];
  logic        busy      [2];
  logic        owner     [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  mem_bus_arbiter #(.ADDR_LENGTH(32), .DATA_LENGTH(32), .READ_LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .m0_req(req[0][0]), .m0_we(wei[0][0]), .m0_addr(addr_i[0][0]), .m0_wdata(wdata_i[0][0]),
    .m0_gnt(gnt[0][0]), .m0_rvalid(rvalid[0][0]), .m0_rdata(rdata_o[0][0]),
    .m1_req(req[0][1]), .m1_we(wei[0][1]), .m1_addr(addr_i[0][1]), .m1_wdata(wdata_i[0][1]),
    .m1_gnt(gnt[0][1]), .m1_rvalid(rvalid[0][1]), .m1_rdata(rdata_o[0][1]),
    .mem_re(mem_re[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0]), .owner(owner[0])
  );

  mem_bus_arbiter #(.ADDR_LENGTH(32), .DATA_LENGTH(32), .READ_LATENCY(3)) dut_l3 (
    .clk(clk), .rst(rst),
    .m0_req(req[1][0]), .m0_we(wei[1][0]), .m0_addr(addr_i[1][0]), .m0_wdata(wdata_i[1][0]),
    .m0_gnt(gnt[1][0]), .m0_rvalid(rvalid[1][0]), .m0_rdata(rdata_o[1][0]),
    .m1_req(req[1][1]), .m1_we(wei[1][1]), .m1_addr(addr_i[1][1]), .m1_wdata(wdata_i[1][1]),
    .m1_gnt(gnt[1][1]), .m1_rvalid(rvalid[1][1]), .m1_rdata(rdata_o[1][1]),
    .mem_re(mem_re[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1]), .owner(owner[1])
  );

  // Reference model: one transaction record per DUT, expected outputs derived from its start cycle.
  int          lat     [2];
  bit          t_valid [2];
  int          t_s     [2];
  bit          t_own   [2];
  bit          t_we    [2];
  logic [31:0] t_addr  [2];
  logic [31:0] t_wdata [2];
  logic [31:0] rd_val  [2];
  bit          last    [2];
  int          free_at [2];

  bit          pend       [2][2];
  int          hold_until [2][2];
  int          ready_at   [2][2];
  bit          rq_we      [2][2];
  logic [31:0] rq_addr    [2][2];
  logic [31:0] rq_wdata   [2][2];

  int cyc;
  bit rand_mode;
  bit auto_wr;
  bit rec;
  int oq0[$];
  int oq1[$];
  int exp_ord[4];
  int n_pass;
  int n_total;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s dut%0d cyc%0d observed=%h expected=%h", tag, k, cyc, obs, exp);
  endtask

  task automatic check_dut(input int k);
    int  e;
    bit  act;
    e   = t_we[k] ? t_s[k] + 2 : t_s[k] + 2 + lat[k];
    act = t_valid[k] && (cyc == t_s[k] + 1);
    chk("busy",      k, 32'(busy[k]),   32'(t_valid[k] && cyc > t_s[k] && cyc < e));
    chk("owner",     k, 32'(owner[k]),  32'(t_valid[k] && t_own[k]));
    chk("mem_re",    k, 32'(mem_re[k]), 32'(act && !t_we[k]));
    chk("mem_we",    k, 32'(mem_we[k]), 32'(act && t_we[k]));
    chk("mem_addr",  k, mem_addr[k],    t_valid[k] ? t_addr[k] : 32'h0);
    chk("mem_wdata", k, mem_wdata[k],   t_valid[k] ? t_wdata[k] : 32'h0);
    for (int m = 0; m < 2; m++) begin
      chk(m == 0 ? "m0_gnt" : "m1_gnt", k, 32'(gnt[k][m]), 32'(act && t_own[k] == m[0]));
      chk(m == 0 ? "m0_rvalid" : "m1_rvalid", k, 32'(rvalid[k][m]),
          32'(t_valid[k] && !t_we[k] && cyc == e && t_own[k] == m[0]));
      chk(m == 0 ? "m0_rdata" : "m1_rdata", k, rdata_o[k][m], rd_val[k]);
    end
  endtask

  task automatic model_reset(input int k);
    t_valid[k] = 1'b0;
    rd_val[k]  = 32'h0;
    last[k]    = 1'b1;
    free_at[k] = cyc + 1;
    for (int m = 0; m < 2; m++) begin
      hold_until[k][m] = -10;
      ready_at[k][m]   = cyc + 1;
    end
  endtask

  task automatic drive(input int k);
    for (int m = 0; m < 2; m++) begin
      if (!pend[k][m] && cyc >= ready_at[k][m]) begin
        if (auto_wr) begin
          pend[k][m] = 1'b1; rq_we[k][m] = 1'b1; rq_addr[k][m] = $urandom; rq_wdata[k][m] = $urandom;
        end else if (rand_mode && $urandom_range(0, 2) == 0) begin
          pend[k][m] = 1'b1; rq_we[k][m] = 1'($urandom_range(0, 1));
          rq_addr[k][m] = $urandom; rq_wdata[k][m] = $urandom;
        end
      end
      req[k][m]     = pend[k][m] || (cyc <= hold_until[k][m]);
      wei[k][m]     = rq_we[k][m];
      addr_i[k][m]  = rq_addr[k][m];
      wdata_i[k][m] = rq_wdata[k][m];
    end
    if (rand_mode) mem_rdata[k] = $urandom;
  endtask

  task automatic update(input int k, input bit r);
    int w;
    if (r) begin
      model_reset(k);
    end else begin
      if (t_valid[k] && !t_we[k] && cyc == t_s[k] + 1 + lat[k]) rd_val[k] = mem_rdata[k];
      if (cyc >= free_at[k] && (pend[k][0] || pend[k][1])) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        w = (pend[k][0] && pend[k][1]) ? (last[k] ? 0 : 1) : (pend[k][0] ? 0 : 1);
`else
        w = pend[k][0] ? 0 : 1;
`endif
        t_valid[k] = 1'b1; t_s[k] = cyc; t_own[k] = w[0]; t_we[k] = rq_we[k][w];
        t_addr[k] = rq_addr[k][w]; t_wdata[k] = rq_wdata[k][w];
        last[k] = w[0];
        pend[k][w] = 1'b0;
        hold_until[k][w] = cyc + 1;
        free_at[k] = rq_we[k][w] ? cyc + 2 : cyc + 2 + lat[k];
        ready_at[k][w] = free_at[k];
      end
    end
  endtask

  task automatic step(input bit r);
    @(negedge clk);
    for (int k = 0; k < 2; k++) check_dut(k);
    if (rec) begin
      if (gnt[0][0] === 1'b1) oq0.push_back(0);
      if (gnt[0][1] === 1'b1) oq0.push_back(1);
      if (gnt[1][0] === 1'b1) oq1.push_back(0);
      if (gnt[1][1] === 1'b1) oq1.push_back(1);
    end
    rst = r;
    for (int k = 0; k < 2; k++) drive(k);
    for (int k = 0; k < 2; k++) update(k, r);
    cyc++;
  endtask

  task automatic issue(input int m, input bit we, input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < 2; k++) begin
      pend[k][m] = 1'b1; rq_we[k][m] = we; rq_addr[k][m] = a; rq_wdata[k][m] = d;
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      done = 1'b1;
      for (int k = 0; k < 2; k++) begin
        if (cyc < free_at[k]) done = 1'b0;
        for (int m = 0; m < 2; m++)
          if (pend[k][m] || cyc < ready_at[k][m]) done = 1'b0;
      end
      step(1'b0);
    end
    chk("drain_done", 0, 32'(done), 32'h1);
  endtask

  initial begin
    lat[0] = 1; lat[1] = 3;
    n_pass = 0; n_total = 0; cyc = 0;
    rand_mode = 1'b0; auto_wr = 1'b0; rec = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_ord[0] = 0; exp_ord[1] = 1; exp_ord[2] = 0; exp_ord[3] = 1;
`else
    exp_ord[0] = 0; exp_ord[1] = 0; exp_ord[2] = 0; exp_ord[3] = 0;
`endif
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mem_rdata[k] = 32'h0;
      for (int m = 0; m < 2; m++) begin
        pend[k][m] = 1'b0; rq_we[k][m] = 1'b0; rq_addr[k][m] = 32'h0; rq_wdata[k][m] = 32'h0;
        req[k][m] = 1'b0; wei[k][m] = 1'b0; addr_i[k][m] = 32'h0; wdata_i[k][m] = 32'h0;
      end
      model_reset(k);
    end
    repeat (2) @(posedge clk);
    step(1'b1);
    step(1'b1);

    // m0 read returning 0xDEADBEEF at both latencies
    mem_rdata[0] = 32'hDEAD_BEEF; mem_rdata[1] = 32'hDEAD_BEEF;
    issue(0, 1'b0, 32'h1001_0000, 32'h0);
    drain();

    // m1 single write
    issue(1, 1'b1, 32'h1001_0024, 32'h0000_00A5);
    drain();

    // both masters requesting writes back-to-back
    rec = 1'b1; auto_wr = 1'b1;
    repeat (8) step(1'b0);
    auto_wr = 1'b0;
    drain();
    rec = 1'b0;
    chk("grant_count", 0, 32'(oq0.size() >= 4), 32'h1);
    chk("grant_count", 1, 32'(oq1.size() >= 4), 32'h1);
    for (int i = 0; i < 4; i++) begin
      if (oq0.size() > i) chk("grant_order", 0, 32'(oq0[i]), 32'(exp_ord[i]));
      if (oq1.size() > i) chk("grant_order", 1, 32'(oq1[i]), 32'(exp_ord[i]));
    end

    // reset during WAIT of an m1 read, then a clean m1 read
    mem_rdata[0] = 32'h1234_5678; mem_rdata[1] = 32'h1234_5678;
    issue(1, 1'b0, 32'h1001_0040, 32'h0);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    drain();
    mem_rdata[0] = 32'hCAFE_F00D; mem_rdata[1] = 32'hCAFE_F00D;
    issue(1, 1'b0, 32'h1001_0044, 32'h0);
    drain();

    // m1 write queued behind an m0 read
    mem_rdata[0] = 32'h0BAD_C0DE; mem_rdata[1] = 32'h0BAD_C0DE;
    issue(0, 1'b0, 32'h0040_0000, 32'h0);
    step(1'b0);
    issue(1, 1'b1, 32'hFFFF_0000, 32'h0000_0055);
    drain();

    // randomized traffic with occasional resets
    rand_mode = 1'b1;
    for (int i = 0; i < 700; i++) step($urandom_range(0, 199) == 0);
    rand_mode = 1'b0;
    drain();
    step(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
